regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter R0_GUARD, default 1, meaning 1 = writes to register 0 are acknowledged but suppressed.
REQ-003 The block SHALL have port Clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port Rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have ports ReqA / ReqB, input, 1 each, write request from requester A (ALU writeback) / B (memory load).
REQ-006 The block SHALL have ports AddrA / AddrB, input, 5 each, destination register number.
REQ-007 The block SHALL have ports DataA / DataB, input, DATA_W each, write data.
REQ-008 The block SHALL have ports AckA / AckB, output, 1 each, one-cycle grant acknowledge.
REQ-009 The block SHALL have port WrEn, output, 1, register file write enable.
REQ-010 The block SHALL have port Awr, output, 5, register file write address, fed to the 5-to-32 write decoder.
REQ-011 The block SHALL have port Din, output, DATA_W, register file write data.
REQ-012 The block SHALL have port Busy, output, 1, high when a request is pending but not granted this cycle.

Function
REQ-013 State machine SHALL have states IDLE, GNT_A, GNT_B; state register and all outputs SHALL be registered.
REQ-014 At each edge, eligible(X) = ReqX and not AckX; eligible requests are arbitrated for that edge.
REQ-015 Only eligible A -> GNT_A; only eligible B -> GNT_B; neither -> IDLE.
REQ-016 Both eligible -> grant the requester not granted most recently (1-bit round-robin pointer, reset to favour A).
REQ-017 The pointer SHALL update only on an actual grant, not in IDLE cycles.
REQ-018 In GNT_X, the cycle after the sampling edge: AckX=1, Awr=AddrX and Din=DataX as sampled, WrEn=1; other Ack=0.
REQ-019 Latency from request sampled to WrEn/Ack SHALL be exactly 1 cycle; back-to-back grants SHALL allow one write per cycle.
REQ-020 Requester SHALL hold ReqX, AddrX, DataX stable until it sees AckX=1; the block is not required to handle withdrawal before Ack.
REQ-021 With R0_GUARD=1 and sampled address 0, AckX SHALL still assert but WrEn SHALL be 0; Awr/Din still carry sampled values.
REQ-022 In IDLE, WrEn=0, AckA=AckB=0; Awr and Din SHALL hold their last values.
REQ-023 Busy SHALL be registered, 1 in any cycle where an eligible request was sampled and not granted (loser of a tie).
REQ-024 Same address from both requesters in consecutive grants SHALL produce two writes in grant order; the later write wins.
REQ-025 A requester re-asserting immediately after its Ack cycle becomes eligible at the next edge (one dead edge, no double grant).

Reset
REQ-026 With Rst=1 at an edge: state=IDLE, pointer favours A, WrEn=0, AckA=AckB=0, Busy=0, Awr=0, Din=0.
REQ-027 Rst asserted during GNT_X SHALL cancel the pending grant; no Ack or WrEn in the cycle following the reset edge.
REQ-028 Requests sampled at an edge with Rst=1 SHALL be ignored; arbitration resumes at the first edge with Rst=0.

Verification
REQ-029 Single A: ReqA=1, AddrA=5, DataA=0x1234 -> next cycle WrEn=1, Awr=5, Din=0x1234, AckA=1; AckA=0 the cycle after.
REQ-030 Simultaneous A and B held high after reset -> grant order A,B,A,B alternating; each Ack pulses once per grant; Busy=1 on loser cycles.
REQ-031 R0 guard: ReqB=1, AddrB=0, DataB=0xFFFFFFFF -> AckB=1, WrEn=0.
REQ-032 Same-address collision: A then B to register 9 with 0x11, 0x22 -> two WrEn cycles, final write Din=0x22.
REQ-033 Reset mid-grant: Rst=1 on edge that follows grant of A -> next cycle WrEn=0, AckA=0, Awr=0, Din=0.
REQ-034 Continuous single requester: ReqA toggled 1 after each Ack -> no back-to-back AckA; at most one AckA per two cycles.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// regfile_write_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   This block arbitrates between two write requesters on the single write
//   port of a register file:
//     - A is the ALU writeback.
//     - B is the memory load.
//   The winner is granted on the edge where its request is sampled. In the
//   following cycle the block presents the winner's address and data with
//   WrEn asserted, and pulses the winner's Ack. When both requesters are
//   eligible, a 1-bit round-robin pointer picks the one that was not granted
//   most recently.
//
// Ports:
//   Clk            sole clock; all state changes on the rising edge
//   Rst            synchronous, active-high reset
//   ReqA / ReqB    write requests; each is held until the matching Ack is seen
//   AddrA / AddrB  destination register numbers
//   DataA / DataB  write data
//   AckA / AckB    one-cycle grant acknowledges
//   WrEn           register file write enable
//   Awr            register file write address (feeds the 5-to-32 decoder)
//   Din            register file write data
//   Busy           an eligible request lost the arbitration on the last edge
//
// Parameters:
//   DATA_W         register data width in bits
//   R0_GUARD       1 = writes to register 0 are acknowledged, but WrEn stays low
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter bit R0_GUARD = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic [4:0]        AddrA,
    input  logic [4:0]        AddrB,
    input  logic [DATA_W-1:0] DataA,
    input  logic [DATA_W-1:0] DataB,
    output logic              AckA,
    output logic              AckB,
    output logic              WrEn,
    output logic [4:0]        Awr,
    output logic [DATA_W-1:0] Din,
    output logic              Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;       // 0: favour A on a tie, 1: favour B
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic                wr_en_q, wr_en_d;
    logic [4:0]          awr_q, awr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                busy_q, busy_d;

    logic                elig_a, elig_b;
    logic                grant_a, grant_b;

    // A requester whose Ack is on the outputs right now is still holding its
    // request from the previous transaction. That requester sits out this
    // edge, so it is never granted twice for the same request.
    assign elig_a  = ReqA && (state_q != GNT_A);
    assign elig_b  = ReqB && (state_q != GNT_B);

    assign grant_a = elig_a && (!elig_b || !ptr_q);
    assign grant_b = elig_b && !grant_a;

    // NOTE: every signal written in this block gets a default first. A path
    //       that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d = IDLE;
        ptr_d   = ptr_q;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        wr_en_d = 1'b0;
        awr_d   = awr_q;     // address and data hold through IDLE cycles
        din_d   = din_q;
        busy_d  = elig_a && elig_b;   // only a tie leaves an eligible loser

        if (grant_a) begin
            state_d = GNT_A;
            ptr_d   = 1'b1;
            ack_a_d = 1'b1;
            awr_d   = AddrA;
            din_d   = DataA;
            wr_en_d = !(R0_GUARD && (AddrA == 5'd0));
        end else if (grant_b) begin
            state_d = GNT_B;
            ptr_d   = 1'b0;
            ack_b_d = 1'b1;
            awr_d   = AddrB;
            din_d   = DataB;
            wr_en_d = !(R0_GUARD && (AddrB == 5'd0));
        end
    end

    // The reset branch clears everything, including a grant that is in
    // flight. Requests sampled on a reset edge are therefore dropped.
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    //       then sees the pre-edge values of every other flop.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            wr_en_q <= 1'b0;
            awr_q   <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            wr_en_q <= wr_en_d;
            awr_q   <= awr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
        end
    end

    assign AckA = ack_a_q;
    assign AckB = ack_b_q;
    assign WrEn = wr_en_q;
    assign Awr  = awr_q;
    assign Din  = din_q;
    assign Busy = busy_q;

endmodule
